// File: rtl/packet_decoder_pkg.sv
// Shared frame layout, idle command, counter width and state encoding for the
// OOK packet generator/decoder pair.
package packet_decoder_pkg;

    localparam int         FrameBits = 12;
    localparam logic [3:0] FrameLen  = 4'(FrameBits);
    localparam int         CntWidth  = 19;
    localparam logic [2:0] CmdIdle   = 3'd7;

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_HIGH  = 2'd2;
    localparam logic [1:0] ST_LOW   = 2'd3;

    typedef logic [CntWidth-1:0] cnt_t;

    // Transmitted MSB first: address, parity, command.
    typedef struct packed {
        logic [7:0] addr;
        logic       parity;
        logic [2:0] cmd;
    } frame_t;

    function automatic logic cmd_parity(input logic [2:0] c);
        return ^c;
    endfunction

endpackage

// File: rtl/ook_pulse_timer.sv
// Synchronizes the OOK envelope, flags its edges and times how long the
// synchronized level has been stable (saturating).
module ook_pulse_timer
    import packet_decoder_pkg::*;
(
    input  logic ref_12mhz,
    input  logic reset_n,
    input  logic ook_in,
    output logic level,
    output logic rise,
    output logic fall,
    output cnt_t count
);

    logic sync_q1;
    logic sync_q2;
    logic level_q;

    always_ff @(posedge ref_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level_q <= 1'b0;
            count   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync_q1 <= ook_in;
            sync_q2 <= sync_q1;
            level_q <= sync_q2;
            if (sync_q2 != level_q) begin
                count <= cnt_t'(1);
            end else if (count != '1) begin
                count <= count + cnt_t'(1);
            end
        end
    end

    // On an edge cycle, count still holds the length of the level just ended.
    assign level = sync_q2;
    assign rise  = sync_q2 & ~level_q;
    assign fall  = ~sync_q2 & level_q;

endmodule

// File: rtl/packet_decoder.sv
// Pulse-width OOK frame decoder: reports a command once it has been received
// twice in a burst, and flags malformed frames.
module packet_decoder
    import packet_decoder_pkg::*;
#(
    parameter int         ChipClocks     = 1600,
    parameter int         GapClocks      = 16000,
    parameter int         BurstGapClocks = 316800,
    parameter logic [7:0] Address        = 8'hA5
) (
    input  logic       ref_12mhz,
    input  logic       reset_n,
    input  logic       ook_in,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam cnt_t ZeroMin  = cnt_t'(ChipClocks / 2);
    localparam cnt_t OneMin   = cnt_t'((3 * ChipClocks) / 2);
    localparam cnt_t OneMax   = cnt_t'((5 * ChipClocks) / 2);
    localparam cnt_t TailLen  = cnt_t'(3 * ChipClocks);
    localparam cnt_t GapLen   = cnt_t'(GapClocks);
    localparam cnt_t BurstLen = cnt_t'(BurstGapClocks);

    logic level;
    logic rise;
    logic fall;
    cnt_t count;

    ook_pulse_timer u_timer (
        .ref_12mhz (ref_12mhz),
        .reset_n   (reset_n),
        .ook_in    (ook_in),
        .level     (level),
        .rise      (rise),
        .fall      (fall),
        .count     (count)
    );

    logic [1:0]           state;
    logic [1:0]           state_d;
    logic [3:0]           bit_cnt;
    logic [3:0]           bit_cnt_d;
    logic [FrameBits-1:0] shift_q;
    logic [FrameBits-1:0] shift_d;
    logic                 err;
    logic                 eval;

    logic       cand_valid;
    logic [2:0] cand_cmd;
    logic [1:0] match_cnt;
    logic       reported;
    logic [2:0] rep_cmd;

    frame_t     frame;
    logic       frame_good;
    logic       accept;
    logic       cand_hit;
    logic [1:0] match_next;
    logic       report;
    logic       burst_idle;

    assign frame      = frame_t'(shift_q);
    assign frame_good = (bit_cnt == FrameLen) && (frame.addr == Address) &&
                        (frame.parity == cmd_parity(frame.cmd));

    always_comb begin
        // NOTE: defaults first so no path through the case infers a latch.
        state_d   = state;
        bit_cnt_d = bit_cnt;
        shift_d   = shift_q;
        err       = 1'b0;
        eval      = 1'b0;
        case (state)
            ST_SYNC: begin
                // On the fall cycle count is still the high length, not a low time.
                if (!level && !fall && count >= GapLen) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (rise) begin
                    state_d   = ST_HIGH;
                    bit_cnt_d = 4'd0;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    if (count < ZeroMin || count > OneMax || bit_cnt == FrameLen) begin
                        err     = 1'b1;
                        state_d = ST_SYNC;
                    end else begin
                        shift_d   = {shift_q[FrameBits-2:0], (count >= OneMin)};
                        bit_cnt_d = bit_cnt + 4'd1;
                        state_d   = ST_LOW;
                    end
                end else if (count > OneMax) begin
                    err     = 1'b1;
                    state_d = ST_SYNC;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_d = ST_HIGH;
                end else if (count >= TailLen) begin
                    eval = 1'b1;
                    if (frame_good) begin
                        state_d = ST_ARMED;
                    end else begin
                        err     = 1'b1;
                        state_d = ST_SYNC;
                    end
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    assign accept     = eval && frame_good;
    assign cand_hit   = cand_valid && (cand_cmd == frame.cmd);
    assign match_next = cand_hit ? ((match_cnt == 2'd3) ? 2'd3 : match_cnt + 2'd1) : 2'd1;
    // Only a repeat of the command already reported in this burst is suppressed.
    assign report     = accept && (match_next >= 2'd2) && !(reported && rep_cmd == frame.cmd);
    assign burst_idle = !level && !fall && (count >= BurstLen);

    always_ff @(posedge ref_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_SYNC;
            bit_cnt    <= 4'd0;
            shift_q    <= '0;
            cmd        <= CmdIdle;
            cmd_valid  <= 1'b0;
            frame_err  <= 1'b0;
            cand_valid <= 1'b0;
            cand_cmd   <= 3'd0;
            match_cnt  <= 2'd0;
            reported   <= 1'b0;
            rep_cmd    <= 3'd0;
        end else begin
            state     <= state_d;
            bit_cnt   <= bit_cnt_d;
            shift_q   <= shift_d;
            cmd_valid <= 1'b0;
            frame_err <= err;

            if (err) begin
                cand_valid <= 1'b0;
                match_cnt  <= 2'd0;
            end else if (accept) begin
                cand_valid <= 1'b1;
                cand_cmd   <= frame.cmd;
                match_cnt  <= match_next;
                if (report) begin
                    cmd       <= frame.cmd;
                    cmd_valid <= 1'b1;
                    reported  <= 1'b1;
                    rep_cmd   <= frame.cmd;
                end
            end

            if (burst_idle) begin
                cand_valid <= 1'b0;
                match_cnt  <= 2'd0;
                reported   <= 1'b0;
            end
        end
    end

    assign busy = (state == ST_HIGH) || (state == ST_LOW);

endmodule

// File: tb/tb_packet_decoder.sv
// Directed bench for packet_decoder with time-scaled parameters (8-cycle chips).
module tb_packet_decoder;

    localparam int Chip     = 8;
    localparam int Gap      = 80;
    localparam int BurstGap = 1584;
    localparam int BitLen   = 3 * Chip;
    localparam int Period   = 792;

    logic       ref_12mhz = 1'b0;
    logic       reset_n   = 1'b1;
    logic       ook_in    = 1'b0;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       frame_err;
    logic       busy;

    int passed = 0;
    int total  = 0;
    int cyc = 0;
    int cv_count = 0;
    int fe_count = 0;
    int overlap_count = 0;
    int cv_cyc = 0;
    int last_fall_cyc = 0;
    int lens[12];

    packet_decoder #(
        .ChipClocks     (Chip),
        .GapClocks      (Gap),
        .BurstGapClocks (BurstGap),
        .Address        (8'hA5)
    ) dut (
        .ref_12mhz (ref_12mhz),
        .reset_n   (reset_n),
        .ook_in    (ook_in),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 ref_12mhz = ~ref_12mhz;

    always @(posedge ref_12mhz) cyc <= cyc + 1;

    always @(negedge ref_12mhz) begin
        if (cmd_valid) begin
            cv_count <= cv_count + 1;
            cv_cyc   <= cyc;
        end
        if (frame_err) fe_count <= fe_count + 1;
        if (cmd_valid && frame_err) overlap_count <= overlap_count + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge ref_12mhz);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        ook_in = v;
        tick(n);
    endtask

    task automatic idle(input int n);
        drive(1'b0, n);
    endtask

    task automatic do_reset();
        ook_in  = 1'b0;
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic fill_frame(input logic [7:0] addr, input logic [2:0] c, input logic flip);
        logic [11:0] bits;
        bits = {addr, (^c) ^ flip, c};
        for (int i = 0; i < 12; i++) lens[i] = bits[11-i] ? 2 * Chip : Chip;
    endtask

    task automatic send_bits(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            drive(1'b1, lens[i]);
            last_fall_cyc = cyc;
            drive(1'b0, (BitLen - lens[i] < 4) ? 4 : BitLen - lens[i]);
        end
    endtask

    task automatic send_frame(input logic [7:0] addr, input logic [2:0] c, input logic flip);
        fill_frame(addr, c, flip);
        send_bits(0, 11);
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({cmd, cmd_valid, frame_err, busy} !== {3'd7, 3'b000})
            $display("FAIL reset_assert: got %b expected %b", {cmd, cmd_valid, frame_err, busy}, {3'd7, 3'b000});
        else passed++;
        tick(3);
        reset_n = 1'b1;
        idle(Gap + 20);
        total++;
        if ({cmd, cmd_valid, frame_err, busy} !== {3'd7, 3'b000})
            $display("FAIL reset_release: got %b expected %b", {cmd, cmd_valid, frame_err, busy}, {3'd7, 3'b000});
        else passed++;
    endtask

    task automatic test_two_frames();
        int c0;
        int lat;
        do_reset();
        idle(100);
        c0 = cv_count;
        send_frame(8'hA5, 3'd2, 1'b0);
        idle(100);
        total++;
        if (cv_count - c0 !== 0) $display("FAIL single_frame_no_report: got %0d expected 0", cv_count - c0);
        else passed++;
        send_frame(8'hA5, 3'd2, 1'b0);
        idle(60);
        total++;
        if (cv_count - c0 !== 1) $display("FAIL two_frames_cmd_valid: got %0d expected 1", cv_count - c0);
        else passed++;
        total++;
        if (cmd !== 3'd2) $display("FAIL two_frames_cmd: got %0d expected 2", cmd);
        else passed++;
        lat = cv_cyc - last_fall_cyc;
        total++;
        if (lat < BitLen + 2 || lat > BitLen + 4)
            $display("FAIL two_frames_latency: got %0d expected %0d", lat, BitLen + 3);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy);
        else passed++;
    endtask

    task automatic test_burst();
        int c0;
        do_reset();
        idle(100);
        c0 = cv_count;
        for (int i = 0; i < 20; i++) begin
            send_frame(8'hA5, 3'd1, 1'b0);
            idle(Period - 12 * BitLen);
        end
        total++;
        if (cv_count - c0 !== 1) $display("FAIL burst_single_report: got %0d expected 1", cv_count - c0);
        else passed++;
        total++;
        if (cmd !== 3'd1) $display("FAIL burst_cmd: got %0d expected 1", cmd);
        else passed++;
        idle(BurstGap + 20);
        send_frame(8'hA5, 3'd1, 1'b0);
        idle(100);
        send_frame(8'hA5, 3'd1, 1'b0);
        idle(60);
        total++;
        if (cv_count - c0 !== 2) $display("FAIL burst_rearm: got %0d expected 2", cv_count - c0);
        else passed++;
    endtask

    task automatic test_bad_addr();
        int c0;
        int f0;
        do_reset();
        idle(100);
        c0 = cv_count;
        f0 = fe_count;
        send_frame(8'hA5, 3'd4, 1'b0);
        idle(100);
        send_frame(8'h5A, 3'd4, 1'b0);
        idle(100);
        total++;
        if (fe_count - f0 !== 1) $display("FAIL bad_addr_err: got %0d expected 1", fe_count - f0);
        else passed++;
        total++;
        if (cv_count - c0 !== 0) $display("FAIL bad_addr_no_valid: got %0d expected 0", cv_count - c0);
        else passed++;
        send_frame(8'hA5, 3'd4, 1'b0);
        idle(100);
        total++;
        if (cv_count - c0 !== 0) $display("FAIL bad_addr_cand_cleared: got %0d expected 0", cv_count - c0);
        else passed++;
        send_frame(8'hA5, 3'd4, 1'b0);
        idle(60);
        total++;
        if (cv_count - c0 !== 1 || cmd !== 3'd4)
            $display("FAIL bad_addr_recover: got %0d/%0d expected 1/4", cv_count - c0, cmd);
        else passed++;
    endtask

    task automatic test_bad_frame_recovery();
        int c0;
        int f0;
        for (int mode = 0; mode < 2; mode++) begin
            do_reset();
            idle(100);
            c0 = cv_count;
            f0 = fe_count;
            if (mode == 0) begin
                fill_frame(8'hA5, 3'd3, 1'b1);
            end else begin
                fill_frame(8'hA5, 3'd3, 1'b0);
                lens[0] = 28;
            end
            send_bits(0, 11);
            idle(40);
            total++;
            if (fe_count - f0 !== 1) $display("FAIL bad_frame_err mode %0d: got %0d expected 1", mode, fe_count - f0);
            else passed++;
            send_frame(8'hA5, 3'd3, 1'b0);
            idle(40);
            idle(100);
            send_frame(8'hA5, 3'd3, 1'b0);
            idle(40);
            total++;
            if (cv_count - c0 !== 0 || fe_count - f0 !== 1)
                $display("FAIL bad_frame_sync_gap mode %0d: got %0d/%0d expected 0/1", mode, cv_count - c0, fe_count - f0);
            else passed++;
            send_frame(8'hA5, 3'd3, 1'b0);
            idle(40);
            total++;
            if (cv_count - c0 !== 1 || cmd !== 3'd3)
                $display("FAIL bad_frame_recover mode %0d: got %0d/%0d expected 1/3", mode, cv_count - c0, cmd);
            else passed++;
        end
    endtask

    task automatic test_pulse_lengths();
        int         tl[6] = '{3, 4, 11, 12, 20, 21};
        logic [2:0] tc[6] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1};
        logic       te[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int c0;
        int f0;
        for (int i = 0; i < 6; i++) begin
            do_reset();
            idle(100);
            c0 = cv_count;
            f0 = fe_count;
            fill_frame(8'hA5, tc[i], 1'b0);
            lens[11] = tl[i];
            send_bits(0, 11);
            idle(40);
            total++;
            if (fe_count - f0 !== (te[i] ? 1 : 0))
                $display("FAIL pulse_len %0d err: got %0d expected %0d", tl[i], fe_count - f0, te[i] ? 1 : 0);
            else passed++;
            if (!te[i]) begin
                send_bits(0, 11);
                idle(40);
                total++;
                if (cv_count - c0 !== 1 || cmd !== tc[i])
                    $display("FAIL pulse_len %0d value: got %0d/%0d expected 1/%0d", tl[i], cv_count - c0, cmd, tc[i]);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int c0;
        do_reset();
        idle(100);
        send_frame(8'hA5, 3'd5, 1'b0);
        idle(40);
        send_frame(8'hA5, 3'd5, 1'b0);
        idle(40);
        total++;
        if (cmd !== 3'd5) $display("FAIL mid_reset_pre_cmd: got %0d expected 5", cmd);
        else passed++;
        fill_frame(8'hA5, 3'd5, 1'b0);
        send_bits(0, 5);
        drive(1'b1, 3);
        total++;
        if (busy !== 1'b1) $display("FAIL mid_reset_busy_before: got %b expected 1", busy);
        else passed++;
        reset_n = 1'b0;
        ook_in  = 1'b0;
        #1;
        total++;
        if ({cmd, cmd_valid, frame_err, busy} !== {3'd7, 3'b000})
            $display("FAIL mid_reset_outputs: got %b expected %b", {cmd, cmd_valid, frame_err, busy}, {3'd7, 3'b000});
        else passed++;
        tick(2);
        reset_n = 1'b1;
        idle(40);
        c0 = cv_count;
        send_frame(8'hA5, 3'd5, 1'b0);
        idle(40);
        send_frame(8'hA5, 3'd5, 1'b0);
        idle(40);
        total++;
        if (cv_count - c0 !== 0) $display("FAIL mid_reset_gap_required: got %0d expected 0", cv_count - c0);
        else passed++;
        idle(100);
        send_frame(8'hA5, 3'd5, 1'b0);
        idle(40);
        send_frame(8'hA5, 3'd5, 1'b0);
        idle(40);
        total++;
        if (cv_count - c0 !== 1 || cmd !== 3'd5)
            $display("FAIL mid_reset_recover: got %0d/%0d expected 1/5", cv_count - c0, cmd);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_two_frames();
        test_burst();
        test_bad_addr();
        test_bad_frame_recovery();
        test_pulse_lengths();
        test_reset_mid_frame();
        total++;
        if (overlap_count !== 0) $display("FAIL valid_err_overlap: got %0d expected 0", overlap_count);
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
